// File: rtl/fifo_drain_ctrl.sv
// Purpose: drains the 8-bit sync FIFO into a valid/ready byte stream via a 2-entry skid buffer (optional FIFO_DRAIN_CNT_EN adds drain_cnt).
// Latency: fifo_rd in cycle N -> capture at end of N+1 -> m_valid in N+2; sustains 1 byte/cycle.
// Backpressure: reads stop while buffered + in-flight bytes reach 2 with no pop; m_data holds while m_ready is low.
module fifo_drain_ctrl #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    output logic              fifo_rd,
    input  logic [DATA_W-1:0] fifo_data_out,
    input  logic              fifo_empty,
    output logic              m_valid,
    output logic [DATA_W-1:0] m_data,
    input  logic              m_ready
`ifdef FIFO_DRAIN_CNT_EN
    ,
    output logic [15:0]       drain_cnt
`endif
);

    logic [1:0]        count;
    logic [1:0]        count_nxt;
    logic [1:0]        count_kept;
    logic [1:0]        occ;
    logic              inflight;
    logic              pop;
    logic [DATA_W-1:0] buf0;
    logic [DATA_W-1:0] buf1;
    logic [DATA_W-1:0] buf0_nxt;
    logic [DATA_W-1:0] buf1_nxt;

    // buf0 is always the oldest entry, so the stream output comes straight from registers
    assign m_valid = (count != 2'd0);
    assign m_data  = buf0;
    assign pop     = m_valid & m_ready;

    // Slots already committed: buffered entries plus the byte whose read is in flight
    assign occ     = count + {1'b0, inflight};

    // A read is allowed when committed slots minus this cycle's pop stay below 2;
    // rst_n gates the strobe so it is low for the whole reset assertion
    assign fifo_rd = rst_n & en & ~fifo_empty & ({1'b0, occ} < (3'd2 + {2'b0, pop}));

    // Next buffer contents: shift on pop, then place the captured byte behind what remains
    always_comb begin
        buf0_nxt   = buf0;
        buf1_nxt   = buf1;
        count_kept = count - {1'b0, pop};
        if (pop) begin
            buf0_nxt = buf1;
        end
        if (inflight) begin
            if (count_kept == 2'd0) begin
                buf0_nxt = fifo_data_out;
            end else begin
                buf1_nxt = fifo_data_out;
            end
        end
        count_nxt = count_kept + {1'b0, inflight};
    end

    // State registers; a read in flight at reset is dropped with inflight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count    <= 2'd0;
            inflight <= 1'b0;
            buf0     <= '0;
            buf1     <= '0;
        end else begin
            count    <= count_nxt;
            inflight <= fifo_rd;
            buf0     <= buf0_nxt;
            buf1     <= buf1_nxt;
        end
    end

`ifdef FIFO_DRAIN_CNT_EN
    // Accepted-beat counter, free-running with natural 16-bit wrap
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drain_cnt <= 16'd0;
        end else if (pop) begin
            drain_cnt <= drain_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fifo_drain_ctrl.sv
// Purpose: directed bench for fifo_drain_ctrl with a behavioural FIFO and a byte scoreboard.
// Latency: inputs change on the falling edge; outputs are sampled 2-3 time units later, before the rising edge.
// Backpressure: m_ready is driven directly by the stimulus sequence.
module tb_fifo_drain_ctrl;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic       fifo_rd;
    logic [7:0] fifo_data_out;
    logic       fifo_empty;
    logic       m_valid;
    logic [7:0] m_data;
    logic       m_ready;
`ifdef FIFO_DRAIN_CNT_EN
    logic [15:0] drain_cnt;
`endif

    fifo_drain_ctrl #(.DATA_W(8)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .en            (en),
        .fifo_rd       (fifo_rd),
        .fifo_data_out (fifo_data_out),
        .fifo_empty    (fifo_empty),
        .m_valid       (m_valid),
        .m_data        (m_data),
        .m_ready       (m_ready)
`ifdef FIFO_DRAIN_CNT_EN
        ,
        .drain_cnt     (drain_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural FIFO: one-cycle read latency; inf makes it look permanently non-empty
    logic [7:0] mem [0:255];
    logic [7:0] wr_ptr;
    logic [7:0] rd_ptr = 8'd0;
    logic       inf;

    assign fifo_empty = !inf && (wr_ptr == rd_ptr);

    // FIFO read port model
    always @(posedge clk) begin
        if (fifo_rd) begin
            fifo_data_out <= mem[rd_ptr];
            rd_ptr        <= rd_ptr + 8'd1;
        end
    end

    int         total = 0;
    int         bad = 0;
    int         cyc = 0;
    int         rd_pulses = 0;
    int         rd_empty_viol = 0;
    int         npops = 0;
    int         sb_extra = 0;
    int         start_cyc;
    int         base;
    logic       sb_on;
    logic [7:0] exp_q [$];
    int         pop_cycles [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Per-cycle monitor: strobe statistics and scoreboard comparison on each accepted beat
    task automatic sample();
        cyc++;
        if (fifo_rd) rd_pulses++;
        if (fifo_rd && fifo_empty) rd_empty_viol++;
        if (m_valid && m_ready) begin
            npops++;
            pop_cycles.push_back(cyc);
            if (sb_on) begin
                if (exp_q.size() == 0) sb_extra++;
                else check("sb_data", {24'd0, m_data}, {24'd0, exp_q.pop_front()});
            end
        end
    endtask

    task automatic tick();
        #2;
        sample();
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b1; m_ready = 1'b1; inf = 1'b0; sb_on = 1'b1;
        mem[0] = 8'h5A; wr_ptr = 8'd1;

        // Reset state with a non-empty FIFO and en high
        #1;
        check("rst_fifo_rd", {31'd0, fifo_rd}, 32'd0);
        check("rst_m_valid", {31'd0, m_valid}, 32'd0);
        check("rst_m_data", {24'd0, m_data}, 32'd0);
`ifdef FIFO_DRAIN_CNT_EN
        check("rst_drain_cnt", {16'd0, drain_cnt}, 32'd0);
`endif
        @(negedge clk);

        // Reset mid-read: 0x5A goes in flight, then reset discards it
        rst_n = 1'b1;
        #1 check("rd_after_release", {31'd0, fifo_rd}, 32'd1);
        tick();
        rst_n = 1'b0;
        #1;
        check("midrst_fifo_rd", {31'd0, fifo_rd}, 32'd0);
        check("midrst_m_valid", {31'd0, m_valid}, 32'd0);
        check("midrst_m_data", {24'd0, m_data}, 32'd0);
        tick();
        rst_n = 1'b1;
        repeat (5) tick();
        check("no_ghost_valid", {31'd0, m_valid}, 32'd0);
        check("no_ghost_pops", npops, 32'd0);

        // Single byte 0xA5: rd in cycle 0 only, valid in cycle 2 only
        mem[1] = 8'hA5; exp_q.push_back(8'hA5); wr_ptr = 8'd2;
        #1 check("single_rd_c0", {31'd0, fifo_rd}, 32'd1);
        tick();
        #1 check("single_rd_c1", {31'd0, fifo_rd}, 32'd0);
        check("single_vld_c1", {31'd0, m_valid}, 32'd0);
        tick();
        #1 check("single_vld_c2", {31'd0, m_valid}, 32'd1);
        check("single_dat_c2", {24'd0, m_data}, 32'h0000_00A5);
        tick();
        #1 check("single_vld_c3", {31'd0, m_valid}, 32'd0);
        tick();

        // Streaming 0x01..0x10 with the sink always ready
        pop_cycles.delete();
        for (int i = 0; i < 16; i++) begin
            mem[2 + i] = 8'(i + 1);
            exp_q.push_back(8'(i + 1));
        end
        wr_ptr = 8'd18;
        start_cyc = cyc + 1;
        for (int k = 0; k < 40 && exp_q.size() != 0; k++) tick();
        check("stream_drained", exp_q.size(), 32'd0);
        check("stream_pops", pop_cycles.size(), 32'd16);
        if (pop_cycles.size() == 16) begin
            check("stream_latency", pop_cycles[0] - start_cyc, 32'd2);
            check("stream_no_bubble", pop_cycles[15] - pop_cycles[0], 32'd15);
        end
        repeat (2) tick();

        // Backpressure: sink stalls 10 cycles while 16 bytes wait
        m_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            mem[18 + i] = 8'(i + 1);
            exp_q.push_back(8'(i + 1));
        end
        wr_ptr = 8'd34;
        base = rd_pulses;
        for (int k = 0; k < 10; k++) begin
            #1;
            if (k >= 2) begin
                check("bp_hold_vld", {31'd0, m_valid}, 32'd1);
                check("bp_hold_dat", {24'd0, m_data}, 32'h0000_0001);
            end
            tick();
        end
        check("bp_rd_pulses", rd_pulses - base, 32'd2);
        pop_cycles.delete();
        m_ready = 1'b1;
        for (int k = 0; k < 40 && exp_q.size() != 0; k++) tick();
        check("bp_drained", exp_q.size(), 32'd0);
        check("bp_pops", pop_cycles.size(), 32'd16);
        repeat (2) tick();

        // Enable gating: en drops the cycle after a read
        for (int i = 0; i < 4; i++) begin
            mem[34 + i] = 8'(8'hC0 + i);
            exp_q.push_back(8'(8'hC0 + i));
        end
        wr_ptr = 8'd38;
        #1 check("eg_rd_c0", {31'd0, fifo_rd}, 32'd1);
        tick();
        en = 1'b0;
        #1 check("eg_rd_off", {31'd0, fifo_rd}, 32'd0);
        base = rd_pulses;
        repeat (5) tick();
        check("eg_no_rd", rd_pulses - base, 32'd0);
        check("eg_inflight_delivered", exp_q.size(), 32'd3);
        en = 1'b1;
        #1 check("eg_rd_resume", {31'd0, fifo_rd}, 32'd1);
        for (int k = 0; k < 40 && exp_q.size() != 0; k++) tick();
        check("eg_drained", exp_q.size(), 32'd0);
        repeat (2) tick();

        check("rd_while_empty", rd_empty_viol, 32'd0);
        check("sb_extra_pops", sb_extra, 32'd0);

`ifdef FIFO_DRAIN_CNT_EN
        // Counter wrap with an endless FIFO and a ready sink
        rst_n = 1'b0; sb_on = 1'b0; inf = 1'b1;
        tick();
        rst_n = 1'b1;
        base = npops;
        for (int k = 0; k < 70000 && (npops - base) < 65535; k++) tick();
        #1 check("cnt_ffff", {16'd0, drain_cnt}, 32'h0000_FFFF);
        for (int k = 0; k < 10 && (npops - base) < 65536; k++) tick();
        #1 check("cnt_wrap0", {16'd0, drain_cnt}, 32'd0);
        for (int k = 0; k < 10 && (npops - base) < 65537; k++) tick();
        #1 check("cnt_wrap1", {16'd0, drain_cnt}, 32'd1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
